// File: rtl/sqrt_arbiter_if.sv
// sqrt_arbiter_if -- bundle of requester, core and response signals for sqrt_arbiter.
//
// Handshake semantics (all signals sampled on the rising clock edge):
//   * req[k] is a level: requester k holds it high until it sees its response,
//     with req_num[k*N +: N] carrying its operand. There is no ready signal;
//     grant tells the requester that its operand has been captured.
//   * core_start is a one-cycle pulse; core_num is stable from that pulse
//     until the arbiter returns to idle. The core answers with a core_done
//     pulse, and core_root/core_err are valid only while core_done is high.
//   * rsp_valid is a one-cycle strobe with no back-pressure; rsp_id/rsp_root/
//     rsp_err hold their values until the next strobe.
//
// Modports:
//   slave  - the arbiter (consumes requests and core results, drives the rest)
//   master - the environment (requesters plus the square-root core)
interface sqrt_arbiter_if #(
  parameter int N    = 16,
  parameter int NREQ = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_num;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              core_start;
  logic [N-1:0]      core_num;
  logic              core_done;
  logic [N/2-1:0]    core_root;
  logic              core_err;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [N/2-1:0]    rsp_root;
  logic              rsp_err;

  modport slave (
    input  req, req_num, core_done, core_root, core_err,
    output grant, busy, core_start, core_num, rsp_valid, rsp_id, rsp_root, rsp_err
  );

  modport master (
    output req, req_num, core_done, core_root, core_err,
    input  grant, busy, core_start, core_num, rsp_valid, rsp_id, rsp_root, rsp_err
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter -- round-robin arbiter sharing one square-root core among NREQ
// requesters. One operation is in flight at a time: IDLE picks a winner and
// latches its operand, ISSUE pulses core_start, WAIT waits for core_done (or a
// timeout), RESP strobes the result back tagged with the winner's index.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous active-high reset
//   bus       - sqrt_arbiter_if.slave: req/req_num in, grant/busy out,
//               core_start/core_num out, core_done/core_root/core_err in,
//               rsp_valid/rsp_id/rsp_root/rsp_err out
//   dbg_state - current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
module sqrt_arbiter #(
  parameter int N       = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 40
) (
  input  logic          clk,
  input  logic          reset,
  sqrt_arbiter_if.slave bus,
  output logic [1:0]    dbg_state
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = N / 2;
  localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [CW-1:0] cnt;
  logic [N-1:0]  num_q;
  logic [IW-1:0] rsp_id_q;
  logic [RW-1:0] rsp_root_q;
  logic          rsp_err_q;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          timeout_hit;

  // Scan starting at ptr and wrapping; the first set bit wins.
  always_comb begin : rr_pick
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // cnt counts completed WAIT cycles without core_done; the cycle that would
  // bring it to TIMEOUT is the last WAIT cycle, so RESP lands exactly TIMEOUT
  // cycles after WAIT entry.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus.core_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. Winner and operand are captured only in IDLE, so
  // later req/req_num activity cannot disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      winner     <= '0;
      cnt        <= '0;
      num_q      <= '0;
      rsp_id_q   <= '0;
      rsp_root_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            winner <= win_idx;
            num_q  <= bus.req_num[win_idx*N +: N];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // core_done has priority over a simultaneous timeout.
          if (bus.core_done) begin
            rsp_id_q   <= winner;
            rsp_root_q <= bus.core_root;
            rsp_err_q  <= bus.core_err;
          end else begin
            cnt <= cnt + 1'b1;
            if (timeout_hit) begin
              rsp_id_q   <= winner;
              rsp_root_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        RESP: ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; grant is derived from the captured winner so
  // it stays one-hot and constant from ISSUE through RESP.
  always_comb begin
    bus.grant      = '0;
    bus.busy       = 1'b0;
    bus.core_start = 1'b0;
    bus.rsp_valid  = 1'b0;
    if (state != IDLE) begin
      bus.grant = GRANT_ONE << winner;
      bus.busy  = 1'b1;
    end
    if (state == ISSUE) bus.core_start = 1'b1;
    if (state == RESP)  bus.rsp_valid  = 1'b1;
    bus.core_num = num_q;
    bus.rsp_id   = rsp_id_q;
    bus.rsp_root = rsp_root_q;
    bus.rsp_err  = rsp_err_q;
    dbg_state    = state;
  end
endmodule

// File: tb/tb_sqrt_arbiter.sv
module tb_sqrt_arbiter;
  localparam int N       = 16;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 40;
  localparam int IW      = 2;
  localparam int RW      = N / 2;
  localparam int W       = IW + RW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  sqrt_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  sqrt_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int wait_cyc = 0;
  int rsp_cyc = 0;
  int grant_bad = 0;
  logic [1:0] prev_state = 2'd0;
  logic       prev_busy = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;

  // core model controls
  int core_delay = 1;
  bit core_hang = 1'b0;
  bit core_err_val = 1'b0;
  bit force_done = 1'b0;
  bit counting = 1'b0;
  int remain = 0;
  bit model_done;

  logic [W-1:0] exp_q[$];

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] isqrt(input logic [N-1:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return RW'(r);
  endfunction

  function automatic logic [W-1:0] pack_rsp(input int id, input int root, input bit err);
    return {IW'(id), RW'(root), err};
  endfunction

  task automatic set_num(input int k, input int v);
    bus.req_num[k*N +: N] = N'(v);
  endtask

  // One clock: advance past the edge, run the core model, the monitors and
  // the response scoreboard.
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    model_done = 1'b0;
    if (reset) begin
      counting = 1'b0;
    end else begin
      if (counting) begin
        remain--;
        if (remain <= 0) begin
          counting   = 1'b0;
          model_done = 1'b1;
        end
      end
      if (bus.core_start) begin
        start_cnt++;
        start_cyc = cyc;
        if (!core_hang) begin
          counting = 1'b1;
          remain   = core_delay;
        end
      end
    end
    bus.core_done = model_done | force_done;
    bus.core_root = model_done ? isqrt(bus.core_num) : '0;
    bus.core_err  = model_done & core_err_val;

    if (dbg_state == S_WAIT && prev_state == S_ISSUE) wait_cyc = cyc;
    prev_state = dbg_state;

    if (bus.busy) begin
      if (!$onehot(bus.grant)) grant_bad++;
      if (prev_busy && bus.grant != prev_grant) grant_bad++;
    end else if (bus.grant != '0) begin
      grant_bad++;
    end
    prev_busy  = bus.busy;
    prev_grant = bus.grant;

    if (bus.rsp_valid) begin
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_scoreboard", 32'({bus.rsp_id, bus.rsp_root, bus.rsp_err}), 32'(e));
      end
    end
  endtask

  task automatic wait_rsp(input int max_cyc, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.rsp_valid && n < max_cyc);
    check({tag, "_rsp_seen"}, 32'(bus.rsp_valid), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_grant"},      32'(bus.grant), 0);
    check({tag, "_busy"},       32'(bus.busy), 0);
    check({tag, "_core_start"}, 32'(bus.core_start), 0);
    check({tag, "_core_num"},   32'(bus.core_num), 0);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid), 0);
    check({tag, "_rsp_id"},     32'(bus.rsp_id), 0);
    check({tag, "_rsp_root"},   32'(bus.rsp_root), 0);
    check({tag, "_rsp_err"},    32'(bus.rsp_err), 0);
    check({tag, "_state"},      32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int s0;
    int prev_rsp;

    reset         = 1'b1;
    bus.req       = '0;
    bus.req_num   = '0;
    bus.core_done = 1'b0;
    bus.core_root = '0;
    bus.core_err  = 1'b0;
    tick();
    tick();
    check_reset_state("por");
    reset = 1'b0;
    tick();
    check("idle_no_req_busy", 32'(bus.busy), 0);

    // Single requester 0, operand 144, core answers after 10 cycles.
    set_num(0, 144);
    core_delay = 10;
    exp_q.push_back(pack_rsp(0, 12, 1'b0));
    s0 = start_cnt;
    bus.req = 4'b0001;
    tick();
    check("t1_core_start", 32'(bus.core_start), 1);
    check("t1_grant", 32'(bus.grant), 1);
    check("t1_core_num", 32'(bus.core_num), 144);
    wait_rsp(60, "t1");
    check("t1_one_start", start_cnt - s0, 1);
    check("t1_latency", rsp_cyc - start_cyc, 11);
    check("t1_grant_in_resp", 32'(bus.grant), 1);
    bus.req = '0;
    tick();
    check("t1_rsp_pulse", 32'(bus.rsp_valid), 0);
    check("t1_root_hold", 32'(bus.rsp_root), 12);
    check("t1_busy_idle", 32'(bus.busy), 0);

    // All four requesting after reset: served 0,1,2,3 back to back.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_num(0, 1);
    set_num(1, 4);
    set_num(2, 9);
    set_num(3, 65535);
    core_delay = 1;
    exp_q.push_back(pack_rsp(0, 1, 1'b0));
    exp_q.push_back(pack_rsp(1, 2, 1'b0));
    exp_q.push_back(pack_rsp(2, 3, 1'b0));
    exp_q.push_back(pack_rsp(3, 255, 1'b0));
    bus.req = 4'b1111;
    prev_rsp = 0;
    for (int k = 0; k < NREQ; k++) begin
      wait_rsp(20, "t2");
      check("t2_id", 32'(bus.rsp_id), k);
      if (k > 0) check("t2_spacing", rsp_cyc - prev_rsp, 4);
      prev_rsp = rsp_cyc;
      bus.req[k] = 1'b0;
    end
    tick();

    // Core never answers: timeout response for requester 2.
    core_hang = 1'b1;
    set_num(2, 50);
    exp_q.push_back(pack_rsp(2, 0, 1'b1));
    bus.req = 4'b0100;
    wait_rsp(TIMEOUT + 20, "t3");
    check("t3_timeout_latency", rsp_cyc - wait_cyc, TIMEOUT);
    check("t3_core_num_stable", 32'(bus.core_num), 50);
    bus.req   = '0;
    core_hang = 1'b0;
    tick();

    // Stray core_done while idle is ignored.
    force_done = 1'b1;
    tick();
    tick();
    check("t3_idle_done_busy", 32'(bus.busy), 0);
    force_done = 1'b0;
    tick();
    check("t3_idle_done_rsp", 32'(bus.rsp_valid), 0);

    // core_done on the very cycle the timeout would fire: core result wins.
    set_num(3, 10000);
    core_delay = TIMEOUT;
    exp_q.push_back(pack_rsp(3, 100, 1'b0));
    bus.req = 4'b1000;
    wait_rsp(TIMEOUT + 20, "t4");
    check("t4_latency", rsp_cyc - wait_cyc, TIMEOUT);
    check("t4_err", 32'(bus.rsp_err), 0);
    check("t4_root", 32'(bus.rsp_root), 100);
    bus.req = '0;
    tick();

    // Core error for requester 1, then a normal operation for requester 0.
    core_delay   = 3;
    core_err_val = 1'b1;
    set_num(1, 81);
    exp_q.push_back(pack_rsp(1, 9, 1'b1));
    bus.req = 4'b0010;
    wait_rsp(20, "t5a");
    check("t5_err", 32'(bus.rsp_err), 1);
    bus.req      = '0;
    core_err_val = 1'b0;
    set_num(0, 16);
    exp_q.push_back(pack_rsp(0, 4, 1'b0));
    bus.req = 4'b0001;
    wait_rsp(20, "t5b");
    check("t5_next_err", 32'(bus.rsp_err), 0);
    check("t5_next_id", 32'(bus.rsp_id), 0);
    bus.req = '0;
    tick();

    // Reset during WAIT for requester 3; afterwards requester 1 goes first.
    core_delay = 20;
    set_num(3, 400);
    bus.req = 4'b1000;
    tick();
    tick();
    check("t6_in_wait", 32'(dbg_state), 32'(S_WAIT));
    set_num(1, 25);
    bus.req = 4'b1010;
    reset = 1'b1;
    tick();
    check_reset_state("t6_rst");
    reset = 1'b0;
    core_delay = 4;
    exp_q.push_back(pack_rsp(1, 5, 1'b0));
    exp_q.push_back(pack_rsp(3, 20, 1'b0));
    tick();
    check("t6_first_grant", 32'(bus.grant), 32'h2);
    wait_rsp(20, "t6a");
    bus.req[1] = 1'b0;
    wait_rsp(20, "t6b");
    bus.req[3] = 1'b0;
    tick();

    // Requester 0 drops req mid-operation; its response still arrives,
    // and operand changes after capture do not reach the core.
    core_delay = 8;
    set_num(0, 36);
    set_num(1, 49);
    exp_q.push_back(pack_rsp(0, 6, 1'b0));
    exp_q.push_back(pack_rsp(1, 7, 1'b0));
    bus.req = 4'b0011;
    tick();
    check("t7_grant0", 32'(bus.grant), 32'h1);
    tick();
    bus.req[0] = 1'b0;
    set_num(0, 99);
    tick();
    check("t7_core_num_held", 32'(bus.core_num), 36);
    check("t7_grant_held", 32'(bus.grant), 32'h1);
    wait_rsp(20, "t7a");
    tick();
    tick();
    check("t7_grant1", 32'(bus.grant), 32'h2);
    check("t7_core_num1", 32'(bus.core_num), 49);
    wait_rsp(20, "t7b");
    bus.req = '0;
    tick();
    tick();

    check("exp_q_drained", exp_q.size(), 0);
    check("grant_onehot_violations", grant_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter N, default 16, operand width in bits (root width N/2).
REQ-002 Parameter NREQ, default 4, number of requesters.
REQ-003 Parameter TIMEOUT, default 40, max cycles waited for core completion.
REQ-004 Clock  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request, held high until served.
REQ-007 req_num  input  NREQ*N  packed operands, requester k at bits [k*N +: N].
REQ-008 grant  output  NREQ  one-hot, requester currently owning the core.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 core_start  output  1  one-cycle start pulse to the square-root core.
REQ-011 core_num  output  N  operand to core, stable from ISSUE until return to IDLE.
REQ-012 core_done  input  1  core completion flag.
REQ-013 core_root  input  N/2  core result, valid while core_done high.
REQ-014 core_err  input  1  core error flag, valid while core_done high.
REQ-015 rsp_valid  output  1  one-cycle result strobe.
REQ-016 rsp_id  output  log2(NREQ)  index of requester owning the response.
REQ-017 rsp_root  output  N/2  result delivered with rsp_valid.
REQ-018 rsp_err  output  1  error (core error or timeout) delivered with rsp_valid.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if any req bit high, winner = first set bit searching upward from ptr with wrap; latch winner index and its req_num; set grant; go ISSUE next cycle.
REQ-021 IDLE with req all zero: remain in IDLE, grant = 0.
REQ-022 ISSUE: core_start = 1 for exactly this one cycle; clear timeout counter; go WAIT.
REQ-023 WAIT: on core_done = 1 capture core_root and core_err; go RESP.
REQ-024 WAIT: counter increments each cycle without core_done; when it reaches TIMEOUT go RESP with rsp_root = 0, rsp_err = 1.
REQ-025 core_done and timeout in same cycle: core_done wins, core result captured.
REQ-026 RESP: rsp_valid = 1 one cycle with rsp_id, rsp_root, rsp_err; ptr = winner+1 mod NREQ; grant cleared; go IDLE.
REQ-027 rsp_root, rsp_err, rsp_id SHALL hold their last values until next RESP; only rsp_valid pulses.
REQ-028 grant stays one-hot and constant from ISSUE through RESP inclusive.
REQ-029 Winner's req dropping mid-operation SHALL NOT abort; response is still issued.
REQ-030 req and req_num changes after capture SHALL NOT affect core_num or the winner.
REQ-031 Latency: req seen in IDLE at cycle 0 -> core_start cycle 1 -> rsp_valid one cycle after core_done is sampled in WAIT.
REQ-032 Minimum spacing between consecutive rsp_valid pulses is 4 cycles; arbiter re-arbitrates in the IDLE cycle after RESP.
REQ-033 Round-robin fairness: with k requesters continuously high, each is served once per k responses.
REQ-034 core_done high outside WAIT SHALL be ignored.

Reset
REQ-035 reset high at a clock edge SHALL force state IDLE, ptr = 0, counter = 0, and grant, busy, core_start, core_num, rsp_valid, rsp_id, rsp_root, rsp_err all 0, from any state.
REQ-036 Operation aborted by reset SHALL produce no rsp_valid; first arbitration after reset starts from requester 0.

Verification
REQ-037 Only req[0], req_num[0] = 144, model core done after 10 cycles with root 12 -> core_num = 144, one core_start, rsp_valid with rsp_id = 0, rsp_root = 12, rsp_err = 0.
REQ-038 After reset all four req high, operands 1, 4, 9, 65535 -> responses in order id 0,1,2,3, roots 1, 2, 3, 255; grant always one-hot.
REQ-039 core_done held low, req[2] with operand 50 -> rsp_valid exactly TIMEOUT cycles after WAIT entry, rsp_id = 2, rsp_root = 0, rsp_err = 1.
REQ-040 Core returns core_err = 1 for req[1] -> rsp_err = 1, rsp_id = 1, next arbitration proceeds normally.
REQ-041 reset asserted during WAIT for req[3] -> all outputs 0 next cycle, no rsp_valid; with req[1] and req[3] still high, req[1] granted first.
REQ-042 req[0] dropped during WAIT with req[1] high -> response for id 0 still delivered, then req[1] granted.
